// File: rtl/ariane_pkg.sv
// Shared core types: the resolved-branch update record fed to the BHT and
// the depth of the queue that buffers those updates.
package ariane_pkg;

   localparam int unsigned VLEN = 64;
   localparam int unsigned BHT_UPD_DEPTH = 4;

   typedef struct packed {
      logic            valid;
      logic [VLEN-1:0] pc;
      logic            taken;
   } bht_update_t;

endpackage

// File: rtl/bht_update_queue_if.sv
// Bundle of the branch-update handshake between the branch unit, the update
// queue and the BHT. The master drives updates and ready; the slave presents the head.
interface bht_update_queue_if;
   import ariane_pkg::*;

   bht_update_t upd;
   bht_update_t bht_update;
   logic        bht_ready;

   modport master (output upd, output bht_ready, input bht_update);
   modport slave  (input upd, input bht_ready, output bht_update);

endinterface

// File: rtl/bht_update_queue.sv
// Circular FIFO buffering resolved branch updates ahead of the BHT.
// Optional overflow statistics are enabled with macro BHT_UPD_STATS_EN.
module bht_update_queue
   import ariane_pkg::*;
#(
   parameter int unsigned DEPTH = ariane_pkg::BHT_UPD_DEPTH
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        flush_i,
   input  logic        debug_mode_i,
   input  bht_update_t upd_i,
   output bht_update_t bht_update_o,
   input  logic        bht_ready_i,
   output logic        full_o,
   output logic        empty_o,
   output logic [15:0] drop_cnt_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [VLEN-1:0] pc_mem_q    [DEPTH];
   logic            taken_mem_q [DEPTH];

   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic full_s;
   logic empty_s;
   logic push_s;
   logic pop_s;

   assign full_s  = (cnt_q == CW'(DEPTH));
   assign empty_s = (cnt_q == {CW{1'b0}});
   assign full_o  = full_s;
   assign empty_o = empty_s;

   // Pop never needs the push of the same cycle, so an empty queue cannot bypass.
   assign pop_s  = !empty_s && bht_ready_i && !flush_i;
   assign push_s = upd_i.valid && !debug_mode_i && !flush_i && (!full_s || pop_s);

   // Next-state for pointers and occupancy; flush wins over everything.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (flush_i) begin
         rd_ptr_d = {PW{1'b0}};
         wr_ptr_d = {PW{1'b0}};
         cnt_d    = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CW'(1'b1);
            2'b01:   cnt_d = cnt_q - CW'(1'b1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr_q <= {PW{1'b0}};
         wr_ptr_q <= {PW{1'b0}};
         cnt_q    <= {CW{1'b0}};
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   // Payload storage; left unreset because the output masks it while empty.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         pc_mem_q[wr_ptr_q]    <= upd_i.pc;
         taken_mem_q[wr_ptr_q] <= upd_i.taken;
      end
   end

   // Head presentation, zeroed while nothing is queued.
   always_comb begin
      bht_update_o = '0;
      if (empty_s) begin
         bht_update_o = '0;
      end else begin
         bht_update_o.valid = 1'b1;
         bht_update_o.pc    = pc_mem_q[rd_ptr_q];
         bht_update_o.taken = taken_mem_q[rd_ptr_q];
      end
   end

`ifdef BHT_UPD_STATS_EN
   logic        overflow_s;
   logic [15:0] drop_q, drop_d;

   assign overflow_s = upd_i.valid && !debug_mode_i && !flush_i && full_s && !pop_s;

   // Saturating overflow counter.
   always_comb begin
      drop_d = drop_q;
      if (overflow_s && (drop_q != 16'hFFFF)) begin
         drop_d = drop_q + 16'd1;
      end else begin
         drop_d = drop_q;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         drop_q <= 16'd0;
      end else begin
         drop_q <= drop_d;
      end
   end

   assign drop_cnt_o = drop_q;
`else
   assign drop_cnt_o = 16'd0;
`endif

endmodule
